// File: rtl/ask_demodulator_if.sv
// ask_demodulator_if: sample stream in, recovered bit stream out.
// master = sample source / bit consumer, slave = demodulator.
interface ask_demodulator_if;
    localparam int unsigned SAMPLE_W = 12;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                bit_out;
    logic                bit_valid;
    logic [SAMPLE_W-1:0] envelope;
    logic                locked;

    modport master (
        output sample_valid,
        output sample,
        input  bit_out,
        input  bit_valid,
        input  envelope,
        input  locked
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output bit_out,
        output bit_valid,
        output envelope,
        output locked
    );
endinterface

// File: rtl/ask_demodulator.sv
// ask_demodulator: integrates |sample| over 2^LOG2_WIN-sample windows and
// slices the window average into a bit. A hunt/lock FSM aligns windows to
// the first carrier burst and drops lock after IDLE_BITS consecutive zeros.
// Optional macro ASK_DEMOD_HYST_EN: two-level hysteresis slicer
// (THRESH_HI / THRESH_LO) instead of the single THRESH_HI slicer.
module ask_demodulator #(
    parameter int unsigned LOG2_WIN  = 5,
    parameter logic [11:0] THRESH_HI = 12'd256,
    parameter logic [11:0] THRESH_LO = 12'd128,
    parameter int unsigned IDLE_BITS = 8
) (
    input logic               clk,
    input logic               reset,
    ask_demodulator_if.slave  bus
);

    localparam int unsigned SW = 12;
    localparam int unsigned AW = SW + LOG2_WIN;
    localparam int unsigned CW = LOG2_WIN;
    localparam int unsigned ZW = 8;
    localparam logic [CW-1:0] CNT_LAST = '1;

    // Reject parameter sets the datapath cannot honour.
    generate
        if (THRESH_LO > THRESH_HI || IDLE_BITS < 1 || IDLE_BITS > 255 || LOG2_WIN < 1) begin : g_param_check
            $error("ask_demodulator: illegal parameter set");
        end
    endgenerate

    typedef enum logic {
        S_HUNT = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [ZW-1:0]  zrun_q, zrun_d;
    logic           bit_q, bit_d;
    logic           valid_q, valid_d;
    logic [SW-1:0]  env_q, env_d;
    logic           locked_q, locked_d;

    logic [SW-1:0]  mag_c;
    logic [AW-1:0]  sum_c;
    logic [SW-1:0]  env_new_c;
    logic           bit_new_c;
    logic [ZW-1:0]  zrun_inc_c;

    // Magnitude, window sum and average of the window closing this cycle.
    always_comb begin
        mag_c      = bus.sample[SW-1] ? SW'(-bus.sample) : bus.sample;
        sum_c      = acc_q + AW'(mag_c);
        env_new_c  = SW'(sum_c >> LOG2_WIN);
        zrun_inc_c = zrun_q + ZW'(1);
    end

    // Bit slicer on the freshly computed envelope.
`ifdef ASK_DEMOD_HYST_EN
    always_comb begin
        if (env_new_c >= THRESH_HI) begin
            bit_new_c = 1'b1;
        end else if (env_new_c < THRESH_LO) begin
            bit_new_c = 1'b0;
        end else begin
            bit_new_c = bit_q;
        end
    end
`else
    always_comb begin
        bit_new_c = (env_new_c >= THRESH_HI);
    end
`endif

    // Next-state and datapath update for the hunt/lock FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        zrun_d  = zrun_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        env_d   = env_q;
        case (state_q)
            S_HUNT: begin
                if (bus.sample_valid && (mag_c >= THRESH_HI)) begin
                    acc_d   = AW'(mag_c);
                    cnt_d   = CW'(1);
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (bus.sample_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        env_d   = env_new_c;
                        bit_d   = bit_new_c;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        if (bit_new_c) begin
                            zrun_d = '0;
                        end else if (zrun_inc_c == ZW'(IDLE_BITS)) begin
                            zrun_d  = '0;
                            state_d = S_HUNT;
                        end else begin
                            zrun_d = zrun_inc_c;
                        end
                    end else begin
                        acc_d = sum_c;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
        locked_d = (state_d == S_LOCK);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_HUNT;
            acc_q    <= '0;
            cnt_q    <= '0;
            zrun_q   <= '0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            env_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            zrun_q   <= zrun_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            env_q    <= env_d;
            locked_q <= locked_d;
        end
    end

    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = valid_q;
    assign bus.envelope  = env_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_ask_demodulator.sv
// Testbench for ask_demodulator: directed scenarios plus random bursts,
// scored against a window-list reference model through an expectation queue.
module tb_ask_demodulator;

    localparam int WIN  = 32;
    localparam int HI   = 256;
`ifdef ASK_DEMOD_HYST_EN
    localparam int LO   = 128;
`endif
    localparam int IDLE = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ask_demodulator_if bus ();

    ask_demodulator #(
        .LOG2_WIN (5),
        .THRESH_HI(12'd256),
        .THRESH_LO(12'd128),
        .IDLE_BITS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit b;
        int env;
        bit lk;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: lock flag, list of magnitudes in the open window,
    // zero-run length and last decided bit/envelope.
    bit m_locked;
    int m_win[$];
    int m_zrun;
    bit m_bit;
    int m_env;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_win.delete();
        m_zrun   = 0;
        m_bit    = 1'b0;
        m_env    = 0;
    endfunction

    function automatic void model_accept(int s);
        int   m;
        int   sum;
        exp_t e;
        m = (s < 0) ? -s : s;
        if (!m_locked) begin
            if (m >= HI) begin
                m_locked = 1'b1;
                m_win.delete();
                m_win.push_back(m);
            end
            return;
        end
        m_win.push_back(m);
        if (m_win.size() < WIN) return;
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_env = sum / WIN;
        m_win.delete();
`ifdef ASK_DEMOD_HYST_EN
        if (m_env >= HI) m_bit = 1'b1;
        else if (m_env < LO) m_bit = 1'b0;
`else
        m_bit = (m_env >= HI);
`endif
        if (m_bit) begin
            m_zrun = 0;
        end else begin
            m_zrun++;
            if (m_zrun == IDLE) begin
                m_zrun   = 0;
                m_locked = 1'b0;
            end
        end
        e.b   = m_bit;
        e.env = m_env;
        e.lk  = m_locked;
        sbq.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; checks held outputs against the model first.
    task automatic step(bit v, int s, bit rst = 1'b0);
        @(negedge clk);
        check("locked",   32'(bus.locked),   32'(m_locked));
        check("envelope", 32'(bus.envelope), 32'(m_env));
        check("bit_out",  32'(bus.bit_out),  32'(m_bit));
        reset            = rst;
        bus.sample_valid = v;
        bus.sample       = 12'(s);
        @(posedge clk);
        if (rst) model_reset();
        else if (v) model_accept(s);
    endtask

    // Monitor: every bit_valid pulse pops one expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.bit_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bit_valid: unexpected pulse, got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    check("sb_bit",    32'(bus.bit_out),  32'(e.b));
                    check("sb_env",    32'(bus.envelope), 32'(e.env));
                    check("sb_locked", 32'(bus.locked),   32'(e.lk));
                end
            end else if (sbq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL bit_valid: missing pulse, got 0 expected 1 (t=%0t)", $time);
                sbq.delete();
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int amps[12] = '{0, 50, 127, 128, 129, 200, 255, 256, 257, 600, 1500, 2047};

    initial begin : stim
        int a;
        int v;
        model_reset();
        reset            = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample       = 12'h7FF;

        // Reset with a full-scale valid sample on the bus.
        repeat (4) step(1'b1, 12'h7FF, 1'b1);
        @(negedge clk);
        check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        check("rst_locked",    32'(bus.locked),    32'd0);

        // Silence in HUNT.
        repeat (200) step(1'b1, 0);
        @(negedge clk);
        check("hunt_locked", 32'(bus.locked), 32'd0);

        // One square window at +/-1000.
        for (int i = 0; i < WIN; i++) step(1'b1, (i % 2) ? -1000 : 1000);
        step(1'b0, 0);
        @(negedge clk);
        check("sq_env",    32'(bus.envelope), 32'd1000);
        check("sq_bit",    32'(bus.bit_out),  32'd1);
        check("sq_locked", 32'(bus.locked),   32'd1);

        // Eight silent windows drop lock; next strong sample re-locks.
        for (int i = 0; i < 8 * WIN; i++) step(1'b1, 0);
        @(negedge clk);
        check("idle_unlock", 32'(bus.locked), 32'd0);
        step(1'b1, 1000);
        @(negedge clk);
        check("relock", 32'(bus.locked), 32'd1);

        // Strong window then +/-200 window.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < WIN; i++) step(1'b1, 1000);
        for (int i = 0; i < WIN; i++) step(1'b1, (i % 2) ? -200 : 200);
        step(1'b0, 0);
        @(negedge clk);
        check("mid_env", 32'(bus.envelope), 32'd200);
`ifdef ASK_DEMOD_HYST_EN
        check("mid_bit", 32'(bus.bit_out), 32'd1);
`else
        check("mid_bit", 32'(bus.bit_out), 32'd0);
`endif

        // -2048 every other cycle.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, -2048);
            if (i != WIN - 1) step(1'b0, 0);
        end
        step(1'b0, 0);
        @(negedge clk);
        check("neg_env", 32'(bus.envelope), 32'd2048);
        check("neg_bit", 32'(bus.bit_out),  32'd1);

        // Random bursts with gaps and occasional mid-window reset.
        step(1'b0, 0, 1'b1);
        for (int w = 0; w < 40; w++) begin
            a = amps[$urandom_range(0, 11)];
            for (int k = 0; k < WIN; k++) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, int'($urandom_range(0, 4095)) - 2048);
                if ($urandom_range(0, 299) == 0) step(1'b1, 2047, 1'b1);
                v = a - int'($urandom_range(0, a / 8));
                if (a == 2047 && $urandom_range(0, 7) == 0) v = -2048;
                else if ($urandom_range(0, 1) == 1) v = -v;
                step(1'b1, v);
            end
        end

        repeat (3) step(1'b0, 0);
        @(negedge clk);
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ask_demodulator.md
# ask_demodulator

Receive-side counterpart of the ASK modulator in the waveform-generator datapath. It takes one amplitude-keyed 12-bit carrier stream (sine, cosine, square or sawtooth, two's complement) and integrates the magnitude over fixed windows of one bit period each. Each window's average is compared against thresholds to recover the modulating bit. A hunt/lock state machine aligns windows to the first carrier burst and drops lock after sustained silence. The recovered bit stream feeds the Avalon-facing bit capture logic.

## Interface
- `LOG2_WIN`, 5: log2 of samples per bit window; window = 2^LOG2_WIN accepted samples.
- `THRESH_HI`, 12'd256: envelope at or above this decodes as 1; also the hunt trigger level.
- `THRESH_LO`, 12'd128: lower hysteresis level; must be ≤ THRESH_HI.
- `IDLE_BITS`, 8: consecutive decoded 0 bits that drop lock; range 1..255.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `sample_valid` in 1: qualifies `sample` this cycle.
- `sample` in 12: carrier sample, signed two's complement.
- `bit_out` out 1: recovered bit, registered; valid when `bit_valid` is high.
- `bit_valid` out 1: one-cycle pulse per completed window.
- `envelope` out 12: last window average magnitude, unsigned.
- `locked` out 1: high while in LOCK.

## Operation
- Magnitude: `mag` = |sample| as 12-bit unsigned. -2048 maps to 2048; no saturation is needed.
- Accumulator width is 12+LOG2_WIN bits and cannot overflow within one window.
- Window counter is LOG2_WIN bits wide.
- Cycles with `sample_valid`=0 change nothing.
- HUNT state (reset state):
  - Accumulator and counter are held at 0.
  - A valid sample with `mag` < THRESH_HI is discarded.
  - A valid sample with `mag` ≥ THRESH_HI loads the accumulator with `mag`, sets the counter to 1, and moves to LOCK. `locked` rises on that same edge.
- LOCK state:
  - Each valid sample adds `mag` to the accumulator and increments the counter.
  - When the counter reaches 2^LOG2_WIN−1 (last sample of the window), the same edge:
    - sets `envelope` = (acc+mag) >> LOG2_WIN;
    - sets `bit_out` per the decision rule below;
    - pulses `bit_valid`;
    - clears the accumulator and counter.
  - Zero-run counter: incremented on each decoded 0, cleared on each decoded 1.
  - When a decoded 0 brings the zero-run count to IDLE_BITS, that bit is still emitted. On the same edge the state returns to HUNT, `locked` falls, and the zero-run counter clears.
- Decision rule: see Configuration.
- A 1-bit decision compares `envelope` against thresholds using the newly computed value, not the previous one.

## Timing
- Reset values:
  - `bit_out`=0, `bit_valid`=0, `envelope`=0, `locked`=0.
  - State = HUNT; accumulator, window counter and zero-run counter = 0.
- Latency: `bit_out`, `envelope` and `bit_valid` update on the clock edge that accepts the final window sample, so they are visible the following cycle.
- `bit_valid` is high for exactly one cycle. `bit_out` and `envelope` hold until the next window completes.
- Minimum window duration is 2^LOG2_WIN cycles (with `sample_valid` held high). Back-to-back `bit_valid` pulses are therefore at least 2^LOG2_WIN cycles apart.
- Reset mid-window discards the partial window; no `bit_valid` is produced for it.
- Reset has priority over a simultaneous `sample_valid`.
- Loss of lock and HUNT re-entry happen on the same edge as the final `bit_valid`. A qualifying sample on the following cycle can re-lock immediately.

## Configuration
- `ASK_DEMOD_HYST_EN` defined:
  - `envelope` ≥ THRESH_HI gives 1.
  - `envelope` < THRESH_LO gives 0.
  - Otherwise the previous `bit_out` is held. The held value counts toward the zero-run only if it is 0.
- `ASK_DEMOD_HYST_EN` undefined:
  - Single threshold: `bit_out` = (`envelope` ≥ THRESH_HI).
  - THRESH_LO is unused.

## Test plan
- Assert `reset` with `sample_valid`=1 and `sample`=12'h7FF → all outputs 0, `locked` stays 0 through reset.
- In HUNT, drive `sample`=0 valid for 200 cycles → `locked`=0 and no `bit_valid`.
- Drive square ±1000 for 32 valid samples from HUNT → `locked`=1 from the first sample, one `bit_valid` after the 32nd, `bit_out`=1, `envelope`=1000.
- Drive one window at ±1000 followed by 8 windows of 0 → nine `bit_valid` pulses (1 then eight 0s), `locked` falls on the ninth pulse, next sample of 1000 re-locks.
- Drive a window at 1000, then a window at ±200 → with HYST_EN, second bit=1 and `envelope`=200; without HYST_EN, second bit=0.
- Drive constant -2048, valid every other cycle, for 32 samples → `bit_valid` once after 63 cycles, `envelope`=2048, `bit_out`=1.
